// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 5-port mesh router:
//   - port index constants (L=0, N=1, S=2, E=3, W=4) and NUM_PORTS
//   - route_xy(): dimension-ordered XY routing decision
// route_xy works on coordinates zero-extended to ROUTE_AW bits.  This lets
// the one package function serve any ADDR_W up to ROUTE_AW, because the
// ordering of unsigned values does not change under zero-extension.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS = 5;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_S = 2;
    localparam int PORT_E = 3;
    localparam int PORT_W = 4;

    // Widest coordinate that route_xy can compare.
    localparam int ROUTE_AW = 16;

    typedef logic [2:0] port_idx_t;

    // X is resolved first, then Y; a flit addressed to this tile goes Local.
    function automatic port_idx_t route_xy(
        input logic [ROUTE_AW-1:0] dst_x,
        input logic [ROUTE_AW-1:0] dst_y,
        input logic [ROUTE_AW-1:0] cur_x,
        input logic [ROUTE_AW-1:0] cur_y
    );
        port_idx_t dir;
        if (dst_x > cur_x) begin
            dir = 3'(PORT_E);
        end else if (dst_x < cur_x) begin
            dir = 3'(PORT_W);
        end else if (dst_y > cur_y) begin
            dir = 3'(PORT_S);
        end else if (dst_y < cur_y) begin
            dir = 3'(PORT_N);
        end else begin
            dir = 3'(PORT_L);
        end
        return dir;
    endfunction

endpackage

// File: rtl/router_5p_param_if.sv
// -----------------------------------------------------------------------------
// router_5p_param_if
// Bundles the five link ports of the router.  All buses are flattened, port p
// occupying slice [p*DATA_W +: DATA_W] (or bit p for 1-bit signals).
//   Data_in  / val_in  : flits arriving from upstream neighbours
//   ret_in             : credit returned to upstream, one pulse per flit popped
//   Data_out / val_out : registered flits leaving towards downstream
//   ret_out            : credits returned by downstream, one pulse = one credit
// modport slave  : the router's view
// modport master : the environment's (neighbours / testbench) view
// -----------------------------------------------------------------------------
interface router_5p_param_if #(
    parameter int DATA_W = 8
);
    import router_pkg::*;

    logic [NUM_PORTS*DATA_W-1:0] Data_in;
    logic [NUM_PORTS-1:0]        val_in;
    logic [NUM_PORTS-1:0]        ret_in;
    logic [NUM_PORTS*DATA_W-1:0] Data_out;
    logic [NUM_PORTS-1:0]        val_out;
    logic [NUM_PORTS-1:0]        ret_out;

    modport slave (
        input  Data_in,
        input  val_in,
        input  ret_out,
        output ret_in,
        output Data_out,
        output val_out
    );

    modport master (
        output Data_in,
        output val_in,
        output ret_out,
        input  ret_in,
        input  Data_out,
        input  val_out
    );

endinterface

// File: rtl/router_in_fifo.sv
// -----------------------------------------------------------------------------
// router_in_fifo
// Synchronous input buffer for one router port.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write din this edge
//   pop      : drop the head entry this edge (ignored when empty)
//   din      : incoming flit
//   full     : DEPTH entries held
//   empty    : no entries held
//   head     : oldest entry, read combinationally so it can be routed and
//              granted in the cycle after it was written
//   ovf      : combinational pulse, a push was refused because no slot was free
// A pop in the same cycle as a push frees its slot first, so a full FIFO
// still accepts the push when it is also being popped.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module router_in_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              push_ok;
    logic              pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        ovf      = push && full && !pop_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/router_5p_param.sv
// -----------------------------------------------------------------------------
// router_5p_param
// 5-port (L, N, S, E, W) mesh router with per-input FIFOs, XY routing,
// round-robin output arbitration and credit-based flow control.
// Single-flit packets: flit[DATA_W-1 -: ADDR_W] is destination X, the next
// ADDR_W bits down are destination Y, the rest is payload.
//   clk, rst             : clock, synchronous active-high reset
//   X_address, Y_address : this tile's mesh coordinate
//   link                 : the five link ports (router_5p_param_if.slave)
//   err_ovf              : sticky per input, a flit arrived while its FIFO
//                          was full and was dropped; cleared only by rst
// Flow: push at edge t, head routed and arbitrated combinationally, grant at
// edge t+1 registers Data_out/val_out and ret_in together with the pop.
// -----------------------------------------------------------------------------
module router_5p_param
    import router_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    X_address,
    input  logic [ADDR_W-1:0]    Y_address,
    router_5p_param_if.slave     link,
    output logic [NUM_PORTS-1:0] err_ovf
);

    localparam int CW = $clog2(CREDITS + 1);

    // Per-input signals
    logic [DATA_W-1:0]    head [NUM_PORTS];
    port_idx_t            route [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] ovf;
    logic [NUM_PORTS-1:0] pop;

    // Grant matrix: gnt_by_out[o*NUM_PORTS + p] = output o grants input p.
    // gnt_by_in is the transpose, so each input can OR its own row.
    logic [NUM_PORTS*NUM_PORTS-1:0] gnt_by_out;
    logic [NUM_PORTS*NUM_PORTS-1:0] gnt_by_in;

    logic [NUM_PORTS-1:0] ret_in_q, ret_in_d;
    logic [NUM_PORTS-1:0] err_ovf_q, err_ovf_d;

    // ---------------------------------------------------------------------
    // Input side: FIFO and route computation per port
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
        router_in_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (link.val_in[gi]),
            .pop   (pop[gi]),
            .din   (link.Data_in[gi*DATA_W +: DATA_W]),
            .full  (full[gi]),
            .empty (empty[gi]),
            .head  (head[gi]),
            .ovf   (ovf[gi])
        );

        assign route[gi] = route_xy(
            ROUTE_AW'(head[gi][DATA_W-1 -: ADDR_W]),
            ROUTE_AW'(head[gi][DATA_W-ADDR_W-1 -: ADDR_W]),
            ROUTE_AW'(X_address),
            ROUTE_AW'(Y_address)
        );

        for (genvar gj = 0; gj < NUM_PORTS; gj++) begin : g_t
            assign gnt_by_in[gi*NUM_PORTS + gj] = gnt_by_out[gj*NUM_PORTS + gi];
        end

        // An input is popped by whichever output granted it (at most one).
        assign pop[gi] = |gnt_by_in[gi*NUM_PORTS +: NUM_PORTS];
    end

    // ---------------------------------------------------------------------
    // Output side: round-robin arbiter, credit counter and output register
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] gnt;
        logic                 found;
        logic [2:0]           sel;
        logic [3:0]           cand;
        logic                 ret;

        logic [DATA_W-1:0]    data_q, data_d;
        logic                 val_q,  val_d;
        logic [2:0]           ptr_q,  ptr_d;
        logic [CW-1:0]        cred_q, cred_d;

        assign ret = link.ret_out[gi];

        always_comb begin
            req   = '0;
            gnt   = '0;
            found = 1'b0;
            sel   = ptr_q;
            cand  = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[p] = !empty[p] && (route[p] == 3'(gi));
            end
            // Search ptr+1, ptr+2, ... wrapping at NUM_PORTS; the last winner
            // is therefore visited last.
            if (cred_q != '0) begin
                for (int i = 1; i <= NUM_PORTS; i++) begin
                    cand = {1'b0, ptr_q} + 4'(i);
                    if (cand >= 4'(NUM_PORTS)) begin
                        cand = cand - 4'(NUM_PORTS);
                    end
                    if (!found && req[cand[2:0]]) begin
                        found = 1'b1;
                        sel   = cand[2:0];
                    end
                end
            end
            if (found) begin
                gnt[sel] = 1'b1;
            end

            ptr_d  = found ? sel : ptr_q;
            val_d  = found;
            data_d = found ? head[sel] : data_q;

            // Grant and return in the same cycle cancel out; a return with
            // the counter already at CREDITS is ignored.
            cred_d = cred_q;
            if (found && !ret) begin
                cred_d = cred_q - CW'(1);
            end else if (!found && ret && (cred_q != CW'(CREDITS))) begin
                cred_d = cred_q + CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                val_q  <= 1'b0;
                ptr_q  <= 3'(NUM_PORTS - 1);
                cred_q <= CW'(CREDITS);
            end else begin
                data_q <= data_d;
                val_q  <= val_d;
                ptr_q  <= ptr_d;
                cred_q <= cred_d;
            end
        end

        // Downstream returned more credits than it was ever given.
        always_ff @(posedge clk) begin
            if (!rst) begin
                assert (!(ret && !found && (cred_q == CW'(CREDITS))));
            end
        end

        assign gnt_by_out[gi*NUM_PORTS +: NUM_PORTS] = gnt;
        assign link.Data_out[gi*DATA_W +: DATA_W]    = data_q;
        assign link.val_out[gi]                      = val_q;
    end

    // ---------------------------------------------------------------------
    // Credit return to upstream and sticky overflow flags
    // ---------------------------------------------------------------------
    always_comb begin
        ret_in_d  = pop;
        err_ovf_d = err_ovf_q | ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_in_q  <= '0;
            err_ovf_q <= '0;
        end else begin
            ret_in_q  <= ret_in_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // A refused push can only ever come from a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((ovf & ~full) == '0);
        end
    end

    assign link.ret_in = ret_in_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_router_5p_param.sv
// -----------------------------------------------------------------------------
// tb_router_5p_param
// Directed bench for router_5p_param (DATA_W=8, ADDR_W=2, FIFO_DEPTH=4,
// CREDITS=4, tile at X=1, Y=1).  Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, i.e. they show the result of
// the edge just passed.
// -----------------------------------------------------------------------------
module tb_router_5p_param;
    import router_pkg::*;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int FD = 4;
    localparam int CR = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [AW-1:0]        x_addr;
    logic [AW-1:0]        y_addr;
    logic [NUM_PORTS-1:0] err_ovf;

    int total = 0;
    int bad   = 0;
    int cnt;
    logic [DW-1:0] last;

    router_5p_param_if #(.DATA_W(DW)) link();

    router_5p_param #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD),
        .CREDITS    (CR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X_address (x_addr),
        .Y_address (y_addr),
        .link      (link),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dout(input int o);
        return link.Data_out[o*DW +: DW];
    endfunction

    task automatic clear_in();
        link.Data_in = '0;
        link.val_in  = '0;
        link.ret_out = '0;
    endtask

    task automatic send(input int p, input logic [DW-1:0] d);
        link.Data_in[p*DW +: DW] = d;
        link.val_in[p]           = 1'b1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Count E outputs over n cycles, remembering the last flit seen.
    task automatic watch_e(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (link.val_out[PORT_E]) begin
                cnt++;
                last = dout(PORT_E);
            end
        end
    endtask

    // Uses up all four E credits with L flits 0xE0..0xE3 (dX=3 -> E).
    task automatic drain_e_credits();
        for (int i = 0; i < 4; i++) begin
            send(PORT_L, 8'hE0 + 8'(i));
            tick();
        end
        clear_in();
        tick();
        tick();
        tick();
    endtask

    initial begin
        x_addr = 2'd1;
        y_addr = 2'd1;
        rst    = 1'b0;
        clear_in();
        do_reset();

        // ---------------- reset state ----------------
        check("rst_val_out", link.val_out, 5'b0);
        check("rst_data_out", link.Data_out, 40'h0);
        check("rst_ret_in", link.ret_in, 5'b0);
        check("rst_err_ovf", err_ovf, 5'b0);

        // ---------------- 1: single flit L -> E, latency ----------------
        send(PORT_L, 8'hF0);
        tick();                       // push edge
        clear_in();
        check("t1_no_out_yet", link.val_out, 5'b0);
        tick();                       // grant edge
        check("t1_val_out", link.val_out, 5'b01000);
        check("t1_data_e", dout(PORT_E), 8'hF0);
        check("t1_ret_in", link.ret_in, 5'b00001);
        tick();
        check("t1_val_drop", link.val_out, 5'b0);
        check("t1_ret_drop", link.ret_in, 5'b0);
        check("t1_data_hold", dout(PORT_E), 8'hF0);

        // ---------------- 2: L and S contend for E ----------------
        do_reset();
        send(PORT_L, 8'hF0);
        send(PORT_S, 8'h90);
        tick();
        clear_in();
        tick();
        check("t2_first_val", link.val_out, 5'b01000);
        check("t2_first_data", dout(PORT_E), 8'hF0);
        check("t2_first_ret", link.ret_in, 5'b00001);
        tick();
        check("t2_second_val", link.val_out, 5'b01000);
        check("t2_second_data", dout(PORT_E), 8'h90);
        check("t2_second_ret", link.ret_in, 5'b00100);
        check("t2_ptr_e", dut.g_out[3].ptr_q, 3'd2);
        tick();
        check("t2_idle", link.val_out, 5'b0);

        // ---------------- 3: credit stall on E ----------------
        do_reset();
        cnt  = 0;
        last = '0;
        for (int i = 0; i < 6; i++) begin
            send(PORT_L, 8'hF1 + 8'(i));
            tick();
            if (link.val_out[PORT_E]) begin
                cnt++;
                last = dout(PORT_E);
            end
        end
        clear_in();
        watch_e(6);
        check("t3_count", cnt, 4);
        check("t3_last", last, 8'hF4);
        check("t3_no_ovf", err_ovf, 5'b0);
        cnt = 0;
        link.ret_out[PORT_E] = 1'b1;
        watch_e(1);
        link.ret_out[PORT_E] = 1'b0;
        watch_e(6);
        check("t3_one_more", cnt, 1);
        check("t3_released", last, 8'hF5);

        // ---------------- 4: overflow on N ----------------
        do_reset();
        drain_e_credits();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send(PORT_N, 8'hC1 + 8'(i));
            tick();
            if (link.val_out[PORT_E]) cnt++;
            if (i == 3) check("t4_ovf_before", err_ovf, 5'b00000);
            if (i == 4) check("t4_ovf_set", err_ovf, 5'b00010);
        end
        clear_in();
        tick();
        tick();
        check("t4_stalled", cnt, 0);
        check("t4_ovf_sticky", err_ovf, 5'b00010);
        for (int i = 0; i < 4; i++) begin
            link.ret_out[PORT_E] = 1'b1;
            watch_e(1);
        end
        link.ret_out[PORT_E] = 1'b0;
        watch_e(6);
        check("t4_kept_count", cnt, 4);
        check("t4_kept_last", last, 8'hC4);
        do_reset();
        check("t4_ovf_cleared", err_ovf, 5'b0);

        // ---------------- 5: Y routing and local delivery from W ----------------
        send(PORT_W, 8'h5A);          // dX=1, dY=1 -> L
        tick();
        send(PORT_W, 8'h43);          // dX=1, dY=0 -> N
        tick();
        check("t5_l_val", link.val_out, 5'b00001);
        check("t5_l_data", dout(PORT_L), 8'h5A);
        send(PORT_W, 8'h6C);          // dX=1, dY=2 -> S
        tick();
        clear_in();
        check("t5_n_val", link.val_out, 5'b00010);
        check("t5_n_data", dout(PORT_N), 8'h43);
        tick();
        check("t5_s_val", link.val_out, 5'b00100);
        check("t5_s_data", dout(PORT_S), 8'h6C);
        check("t5_s_ret", link.ret_in, 5'b10000);

        // ---------------- 6: reset with flits buffered ----------------
        do_reset();
        drain_e_credits();
        for (int i = 0; i < 3; i++) begin
            send(PORT_N, 8'hC8 + 8'(i));
            tick();
        end
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        begin
            logic [NUM_PORTS-1:0] any_val;
            any_val = '0;
            for (int i = 0; i < 8; i++) begin
                tick();
                any_val = any_val | link.val_out;
            end
            check("t6_no_val", any_val, 5'b0);
        end
        check("t6_data_zero", link.Data_out, 40'h0);
        check("t6_ret_zero", link.ret_in, 5'b0);
        for (int i = 0; i < 4; i++) begin
            send(PORT_L, 8'hD0 + 8'(i));
            tick();
            if (i > 0) begin
                check("t6_stream_val", link.val_out[PORT_E], 1'b1);
                check("t6_stream_data", dout(PORT_E), 8'hD0 + 8'(i - 1));
            end
        end
        clear_in();
        tick();
        check("t6_last_val", link.val_out[PORT_E], 1'b1);
        check("t6_last_data", dout(PORT_E), 8'hD3);
        tick();
        check("t6_idle", link.val_out, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_5p_param.md
Name: router_5p_param

Overview:
- Parametrised next-generation 5-port mesh NoC router: ports Local, North, South, East and West.
- Generalises data and address widths, adds per-input buffering of configurable depth, credit-based flow control, and round-robin output arbitration.
- Single-flit packets, dimension-ordered XY routing.
- Tiled into a 2D mesh; each router is given its own X_address/Y_address.

Parameters:
- DATA_W, 8: flit width in bits.
- ADDR_W, 2: width of each mesh coordinate.
- FIFO_DEPTH, 4: entries per input buffer; power of two, >= 2.
- CREDITS, 4: initial credit count per output; equals the downstream FIFO_DEPTH.

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- X_address  in  ADDR_W  this router's column.
- Y_address  in  ADDR_W  this router's row.
- Data_in  in  5*DATA_W  input flits; slice p = [p*DATA_W +: DATA_W]; port index L=0, N=1, S=2, E=3, W=4.
- val_in  in  5  flit valid per input port.
- ret_in  out  5  credit return to upstream; one pulse per flit popped.
- Data_out  out  5*DATA_W  output flits, registered.
- val_out  out  5  output flit valid, registered.
- ret_out  in  5  credit return from downstream; one pulse = one credit.
- err_ovf  out  5  sticky flag: flit arrived while that input FIFO was full.

Behaviour:
- Reset values: Data_out=0, val_out=0, ret_in=0, err_ovf=0, all FIFOs empty, credit counters=CREDITS, round-robin pointers=4 (so L has highest priority first).
- Flit format: destination X = flit[DATA_W-1 -: ADDR_W]; destination Y = the next ADDR_W bits down; the remainder is payload, passed unchanged.
- Routing (combinational, on each FIFO head):
  - dX>X_address → E; dX<X_address → W.
  - Otherwise dY>Y_address → S; dY<Y_address → N.
  - Otherwise → L.
  - U-turns are not checked.
- Input FIFO:
  - At the edge where val_in[p]=1 the flit is pushed.
  - If the FIFO is full, the flit is dropped and err_ovf[p] is set; it stays set until rst.
  - Push and pop in the same cycle are legal, including when the FIFO is full: pop frees a slot first, so the push succeeds.
- Allocation, each cycle for each output o:
  - Requesters are the non-empty inputs whose head routes to o.
  - A grant is issued only if credit[o]>0.
  - Round-robin search starts at ptr[o]+1 mod 5; on a grant, ptr[o] = granted index.
  - Each input has one head, so it is never granted twice in one cycle.
- On grant (edge t+1): Data_out[o] is loaded with the head flit, val_out[o]=1 for one cycle, the input is popped, and ret_in[p]=1 for one cycle.
  - Outputs with no grant: val_out[o]=0; Data_out[o] holds its last value.
- Latency: flit pushed at edge t into an empty FIFO, uncontended → val_out high in the cycle after edge t+1 (2 edges). Throughput is 1 flit/cycle/output.
- Credit counter per output:
  - −1 on grant, +1 on ret_out[o]; both in the same cycle → unchanged.
  - Saturates at CREDITS; an extra ret_out is ignored (simulation assertion).
  - Never goes below 0.
  - Width is clog2(CREDITS+1).
- rst asserted mid-operation: all in-flight flits are discarded, and every output returns to its reset value at that edge.

Decomposition:
- Package router_pkg:
  - Port index constants L/N/S/E/W and NUM_PORTS=5.
  - route_xy function, parametrised by ADDR_W.
- Sub-module router_in_fifo: parametrised synchronous FIFO with push, pop, full, empty, head and an overflow pulse; instantiated 5×.
- Arbiter logic stays in the top module as a generate loop.

Test Plan:
- Reset, then Data_in L=0xF0 with val_in[L]=1 for 1 cycle, X/Y=1/1 → val_out[E]=1, Data_out[E]=0xF0, 2 edges after the push; ret_in[L] pulses at the grant edge.
- L=0xF0 and S=0x90 in the same cycle, both routed to E → E outputs 0xF0 (L) then 0x90 (S) on consecutive cycles; ptr[E] ends at 2.
- Hold ret_out[E]=0 while sending 6 flits L→E → exactly 4 leave E, the rest wait in the FIFO; one ret_out[E] pulse releases exactly one more.
- val_in[N]=1 for 6 consecutive cycles with E credits at 0 → the 5th and 6th flits are dropped and err_ovf[N]=1 stays high; rst clears it.
- Flits 0x50 (dX=1, dY=1), 0x40 (dY=0) and 0x60 (dY=2) on W → outputs L, N and S respectively, with payload bits unchanged.
- Assert rst while 3 flits are buffered → no val_out after reset, and credits read back as 4 (check by sending 4 flits with no stall).
